fp_square_seq: RTL and testbench
================================

FP_SQUARE_SEQ -- requirements
Module: fp_square_seq

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1: the number of multiplier bits retired per MUL cycle; legal values are 1, 2, 4 and 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port EN, input, 1 bit: block enable; low stalls the FSM and forces result to 0.
REQ-005 SHALL have port start, input, 1 bit: request strobe, sampled in IDLE only.
REQ-006 SHALL have port A, input, 32 bits: IEEE-754 single-precision operand.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-009 SHALL have port result, output, 32 bits: A*A in IEEE-754 single precision.
REQ-010 SHALL have ports overflow, underflow and exception, each an output of 1 bit: status flags, valid with done.

Function
REQ-011 SHALL implement the states IDLE -> MUL -> NORM -> DONE -> IDLE.
REQ-012 IDLE SHALL leave on start=1 and EN=1, register A and clear the 48-bit product accumulator.
REQ-013 MUL SHALL shift-add the 24-bit significand {1,A[22:0]} by itself, retiring BITS_PER_CYCLE bits per cycle, for 24/BITS_PER_CYCLE cycles.
REQ-014 NORM SHALL take product bit 47 as the normalise select, compute exponent = 2*E - 127 + bit47, round, and apply the special cases.
REQ-015 DONE SHALL update result and the flags and pulse done for 1 cycle; the FSM then returns to IDLE.
REQ-016 The latency from the sampled start edge to done high SHALL be 24/BITS_PER_CYCLE + 2 cycles (26 cycles at the default).
REQ-017 The result sign SHALL always be 0, except for NaN outputs.
REQ-018 Exponent arithmetic SHALL use a 10-bit signed intermediate.
REQ-019 A biased exponent >= 255 SHALL set overflow=1 and give result 32'h7F800000.
REQ-020 A biased exponent <= 0 SHALL set underflow=1 and give result 32'h00000000.
REQ-021 Rounding that carries out of the mantissa SHALL increment the exponent, and the overflow check SHALL be re-applied after the increment.
REQ-022 A zero or denormal A SHALL be flushed to zero and give result 0; underflow SHALL be set only for a denormal A.
REQ-023 An infinite A SHALL give 32'h7F800000 with exception=1.
REQ-024 A NaN A SHALL give 32'h7FC00000 with exception=1.
REQ-025 Special cases SHALL still take the full latency.
REQ-026 start asserted while busy SHALL be ignored, with no queueing.
REQ-027 EN low SHALL freeze the state and the accumulator and drive result=0.
REQ-028 When EN returns high, the FSM SHALL resume and done SHALL slip by the number of stalled cycles.
REQ-029 result and the flags SHALL hold their value until the next DONE.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE and clear the accumulator and the captured A.
REQ-031 rst_n low SHALL drive busy=0, done=0, result=0, overflow=0, underflow=0 and exception=0.
REQ-032 Reset during MUL or NORM SHALL abort the operation with no done pulse.
REQ-033 After reset release, the first start SHALL be accepted on the first rising edge at which start=1 and EN=1.

Configuration
REQ-034 With macro FP_SQUARE_ROUND_NEAREST_EN defined, NORM SHALL round to nearest-even using the guard bit and a sticky bit (the OR of all lower product bits).
REQ-035 Without FP_SQUARE_ROUND_NEAREST_EN, NORM SHALL truncate, and the rounding logic SHALL be absent.

Verification
REQ-036 The bench SHALL check A=32'h40000000 (2.0) -> result 32'h40800000, all flags 0, done exactly 26 cycles after start.
REQ-037 The bench SHALL check A=32'hC0400000 (-3.0) -> result 32'h41100000 (+9.0).
REQ-038 The bench SHALL check A=32'h3F800801 -> result 32'h3F801003 with FP_SQUARE_ROUND_NEAREST_EN defined and 32'h3F801002 without it.
REQ-039 The bench SHALL check overflow, underflow and NaN handling:
- 32'h60AD78EC (1e20) -> 32'h7F800000 with overflow=1;
- 32'h1E1CE3A2 (~1e-20) -> 0 with underflow=1;
- 32'h7FC00001 -> 32'h7FC00000 with exception=1.
REQ-040 The bench SHALL check that start pulses during busy are ignored and that EN held low for 5 mid-MUL cycles gives done at cycle 31 with the correct result.
REQ-041 The bench SHALL check that rst_n low at MUL cycle 10 gives no done pulse and all outputs 0, and that the next start completes normally.

Source files
------------

// File: rtl/fp_square_seq.sv
// fp_square_seq: sequential IEEE-754 single-precision squarer (shift-add multiplier, IDLE/MUL/NORM/DONE FSM).
// Optional macro FP_SQUARE_ROUND_NEAREST_EN selects round-to-nearest-even; the default build truncates.

module fp_square_seq #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic        start,
    input  logic [31:0] A,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        exception
);

    localparam int NUM_STEPS = 24 / BITS_PER_CYCLE;
    localparam int CNT_W     = $clog2(NUM_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t state_q, state_d;

    // The sign of A never reaches the result, so only the magnitude is captured.
    logic [30:0]             a_q;
    logic [23:0]             mplr_q;
    logic [47:0]             acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [31:0]             normRes_q;
    logic                    normOvf_q, normUnf_q, normExc_q;
    logic [31:0]             result_q;
    logic                    ovf_q, unf_q, exc_q;
    logic                    done_q;

    logic [23:0]                   signif;
    logic [BITS_PER_CYCLE-1:0]     chunk;
    logic [23+BITS_PER_CYCLE:0]    partial;
    logic [47+BITS_PER_CYCLE:0]    accSum;
    logic [47:0]                   accNext;

    logic                prodTop;
    logic [22:0]         mantTrunc;
    logic signed [9:0]   expRaw;
    logic signed [9:0]   expFinal;
    logic [22:0]         mantFinal;
    logic [31:0]         normResult;
    logic                normOvf, normUnf, normExc;
    logic                unusedBits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (EN) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (cnt_q == LAST_STEP) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Partial product lands in the upper half, then the whole accumulator
    // shifts right, so after NUM_STEPS steps the full 48-bit product is in place.
    assign signif = {1'b1, a_q[22:0]};
    assign chunk  = mplr_q[BITS_PER_CYCLE-1:0];

    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (chunk[i]) begin
                partial = partial + ({{BITS_PER_CYCLE{1'b0}}, signif} << i);
            end
        end
    end

    assign accSum  = {{BITS_PER_CYCLE{1'b0}}, acc_q} + {partial, 24'd0};
    assign accNext = accSum[47+BITS_PER_CYCLE:BITS_PER_CYCLE];

    assign prodTop   = acc_q[47];
    assign mantTrunc = prodTop ? acc_q[46:24] : acc_q[45:23];
    assign expRaw    = {1'b0, a_q[30:23], 1'b0} - 10'd127 + {9'd0, prodTop};

`ifdef FP_SQUARE_ROUND_NEAREST_EN
    logic        guardBit, stickyBit, roundUp;
    logic [23:0] mantRounded;

    always_comb begin
        guardBit    = prodTop ? acc_q[23] : acc_q[22];
        stickyBit   = prodTop ? |acc_q[22:0] : |acc_q[21:0];
        roundUp     = guardBit & (stickyBit | mantTrunc[0]);
        mantRounded = {1'b0, mantTrunc} + {23'd0, roundUp};
        mantFinal   = mantRounded[22:0];
        expFinal    = expRaw + {9'd0, mantRounded[23]};
    end

    assign unusedBits = ^{A[31], accSum[BITS_PER_CYCLE-1:0]};
`else
    always_comb begin
        mantFinal = mantTrunc;
        expFinal  = expRaw;
    end

    assign unusedBits = ^{A[31], accSum[BITS_PER_CYCLE-1:0], acc_q[22:0]};
`endif

    // Overflow is judged on the exponent after any rounding carry.
    always_comb begin
        normResult = 32'd0;
        normOvf    = 1'b0;
        normUnf    = 1'b0;
        normExc    = 1'b0;
        if (a_q[30:23] == 8'hFF) begin
            normExc    = 1'b1;
            normResult = (a_q[22:0] != 23'd0) ? 32'h7FC00000 : 32'h7F800000;
        end else if (a_q[30:23] == 8'h00) begin
            normUnf = (a_q[22:0] != 23'd0);
        end else if (expFinal >= 10'sd255) begin
            normOvf    = 1'b1;
            normResult = 32'h7F800000;
        end else if (expFinal <= 10'sd0) begin
            normUnf = 1'b1;
        end else begin
            normResult = {1'b0, expFinal[7:0], mantFinal};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            normRes_q <= '0;
            normOvf_q <= 1'b0;
            normUnf_q <= 1'b0;
            normExc_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            exc_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= EN && (state_q == DONE);
            if (EN) begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            a_q    <= A[30:0];
                            mplr_q <= {1'b1, A[22:0]};
                            acc_q  <= '0;
                            cnt_q  <= '0;
                        end
                    end
                    MUL: begin
                        acc_q  <= accNext;
                        mplr_q <= mplr_q >> BITS_PER_CYCLE;
                        cnt_q  <= cnt_q + CNT_W'(1);
                    end
                    NORM: begin
                        normRes_q <= normResult;
                        normOvf_q <= normOvf;
                        normUnf_q <= normUnf;
                        normExc_q <= normExc;
                    end
                    DONE: begin
                        result_q <= normRes_q;
                        ovf_q    <= normOvf_q;
                        unf_q    <= normUnf_q;
                        exc_q    <= normExc_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign result    = EN ? result_q : 32'd0;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign exception = exc_q;

endmodule

// File: tb/tb_fp_square_seq.sv
// tb_fp_square_seq: directed literal checks plus randomized traffic against an arithmetic reference model.
// Honours FP_SQUARE_ROUND_NEAREST_EN the same way the design does.

module tb_fp_square_seq;

    localparam int BPC = 1;
    localparam int LAT = 24 / BPC + 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        EN    = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A     = 32'd0;
    logic        busy, done, overflow, underflow, exception;
    logic [31:0] result;

    int assertCnt = 0;
    int failCnt   = 0;
    int cycleCnt  = 0;
    int doneCount = 0;

    logic        mBusy = 1'b0;
    logic        mDone = 1'b0;
    int          mCnt  = 0;
    logic [34:0] mHeld = '0;
    logic [34:0] mPend = '0;

    fp_square_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .EN        (EN),
        .start     (start),
        .A         (A),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleCnt, actual, expected);
        end
    endtask

    // Exact integer square of the significand, normalised and rounded from first principles.
    function automatic logic [34:0] refSquare(input logic [31:0] a);
        int              e, shift, ex;
        longint unsigned m, p, mant;
`ifdef FP_SQUARE_ROUND_NEAREST_EN
        longint unsigned rem, half;
`endif
        e = int'(a[30:23]);
        if (e == 255) return (a[22:0] != 23'd0) ? {32'h7FC00000, 3'b001} : {32'h7F800000, 3'b001};
        if (e == 0) return {32'h0, 1'b0, (a[22:0] != 23'd0), 1'b0};
        m = {40'd0, 1'b1, a[22:0]};
        p = m * m;
        if (p >= (64'd1 << 47)) begin
            shift = 24;
            ex    = 2 * e - 127 + 1;
        end else begin
            shift = 23;
            ex    = 2 * e - 127;
        end
        mant = p >> shift;
`ifdef FP_SQUARE_ROUND_NEAREST_EN
        rem  = p - (mant << shift);
        half = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && mant[0])) mant++;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            ex++;
        end
`endif
        if (ex >= 255) return {32'h7F800000, 3'b100};
        if (ex <= 0) return {32'h0, 3'b010};
        return {1'b0, 8'(ex), 23'(mant), 3'b000};
    endfunction

    function automatic logic [31:0] randA();
        logic       s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom % 8)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'(189 + $urandom % 6);
            3:       e = 8'(61 + $urandom % 6);
            default: e = 8'($urandom);
        endcase
        if ($urandom % 6 == 0) f = ($urandom % 2 == 0) ? 23'h7FFFFF : 23'h000000;
        return {s, e, f};
    endfunction

    // Transaction-level model: counts enabled edges since acceptance.
    always @(posedge clk) begin
        cycleCnt++;
        if (!rst_n) begin
            mBusy = 1'b0;
            mDone = 1'b0;
            mCnt  = 0;
            mHeld = '0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                if (EN) begin
                    mCnt++;
                    if (mCnt == LAT) begin
                        mBusy = 1'b0;
                        mDone = 1'b1;
                        mHeld = mPend;
                    end
                end
            end else if (start && EN) begin
                mBusy = 1'b1;
                mCnt  = 0;
                mPend = refSquare(A);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_ctrl", {30'd0, busy, done}, 32'd0);
            checkOutput("rst_result", result, 32'd0);
            checkOutput("rst_flags", {29'd0, overflow, underflow, exception}, 32'd0);
        end else begin
            checkOutput("ctrl", {30'd0, busy, done}, {30'd0, mBusy, mDone});
            checkOutput("result", result, EN ? mHeld[34:3] : 32'd0);
            checkOutput("flags", {29'd0, overflow, underflow, exception}, {29'd0, mHeld[2:0]});
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic applyStimulus(input logic [31:0] a, output int t0);
        @(posedge clk);
        #2;
        A     = a;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        t0    = cycleCnt;
    endtask

    task automatic waitDone(input int t0, output int lat, output bit found);
        found = 1'b0;
        lat   = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                lat   = cycleCnt - t0;
                break;
            end
        end
    endtask

    task automatic runDirected(input string name, input logic [31:0] a, input logic [31:0] expRes,
                               input logic [2:0] expFlags, input int expLat);
        int t0, lat;
        bit found;
        applyStimulus(a, t0);
        waitDone(t0, lat, found);
        checkOutput({name, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            checkOutput({name, "_latency"}, lat, expLat);
            checkOutput({name, "_result"}, result, expRes);
            checkOutput({name, "_flags"}, {29'd0, overflow, underflow, exception}, {29'd0, expFlags});
        end
    endtask

    initial begin
        int t0, lat, d0;
        bit found;
        logic [31:0] roundExp;

`ifdef FP_SQUARE_ROUND_NEAREST_EN
        roundExp = 32'h3F801003;
`else
        roundExp = 32'h3F801002;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        runDirected("two",    32'h40000000, 32'h40800000, 3'b000, LAT);
        runDirected("neg3",   32'hC0400000, 32'h41100000, 3'b000, LAT);
        runDirected("round",  32'h3F800801, roundExp,     3'b000, LAT);
        runDirected("ovf",    32'h60AD78EC, 32'h7F800000, 3'b100, LAT);
        runDirected("unf",    32'h1E1CE3A2, 32'h00000000, 3'b010, LAT);
        runDirected("nan",    32'h7FC00001, 32'h7FC00000, 3'b001, LAT);
        runDirected("inf",    32'hFF800000, 32'h7F800000, 3'b001, LAT);
        runDirected("zero",   32'h80000000, 32'h00000000, 3'b000, LAT);
        runDirected("denorm", 32'h00000001, 32'h00000000, 3'b010, LAT);

        // Starts during busy must neither restart nor queue.
        applyStimulus(32'h40400000, t0);
        for (int k = 0; k < 3; k++) begin
            repeat (4) @(posedge clk);
            #2;
            A     = 32'h7FC00001;
            start = 1'b1;
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        waitDone(t0, lat, found);
        checkOutput("ignore_latency", lat, LAT);
        checkOutput("ignore_result", result, 32'h41100000);
        checkOutput("ignore_flags", {29'd0, overflow, underflow, exception}, 32'd0);
        @(posedge clk);
        #1 d0 = doneCount;
        repeat (LAT + 4) @(posedge clk);
        #1 checkOutput("ignore_no_second_done", doneCount - d0, 32'd0);

        // EN low for 5 mid-MUL edges delays done to LAT+5.
        applyStimulus(32'h40000000, t0);
        repeat (8) @(posedge clk);
        #2 EN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("stall_result_zero", result, 32'd0);
        checkOutput("stall_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(posedge clk);
        #2 EN = 1'b1;
        waitDone(t0, lat, found);
        checkOutput("stall_latency", lat, LAT + 5);
        checkOutput("stall_result", result, 32'h40800000);

        // Reset at MUL cycle 10 aborts with no done.
        applyStimulus(32'h40000000, t0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_ctrl", {30'd0, busy, done}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_flags", {29'd0, overflow, underflow, exception}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 d0 = doneCount;
        repeat (LAT + 10) @(posedge clk);
        #1 checkOutput("abort_no_done", doneCount - d0, 32'd0);
        runDirected("after_abort", 32'h40400000, 32'h41100000, 3'b000, LAT);

        // Randomized traffic; the compare process checks every cycle.
        d0 = doneCount;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk);
            #2;
            A     = randA();
            start = ($urandom % 6 == 0);
            EN    = ($urandom % 10 != 0);
            rst_n = ($urandom % 1500 != 0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        EN    = 1'b1;
        start = 1'b0;
        repeat (3 * LAT) @(posedge clk);
        #1 checkOutput("rand_activity", 32'((doneCount - d0) > 50), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
